playlist_sequencer: RTL and testbench

- Controller that sequences the song player across a playlist: loads the song index, restarts the player between tracks, gates pause, and advances on the player's end-of-song pulse.
- Sits between the auto-play mode FSM and the player. It replaces direct index/pause/restart wiring with repeat modes, skip next/prev and an inter-song gap.

---
 rtl/playlist_sequencer_pkg.sv | 49 ++++
 rtl/playlist_sequencer_gap_timer.sv | 34 +++
 rtl/playlist_sequencer.sv | 142 ++++++++++++++
 tb/tb_playlist_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/playlist_sequencer_pkg.sv
// Shared definitions for the playlist sequencer.
//   state_e            : controller state codes, also exported on state_o
//   REP_SEQ/ALL/ONE    : repeat_mode encodings (2'b11 behaves as REP_SEQ)
//   next_idx/prev_idx  : playlist index step with explicit wrap compare
//   clamp_idx          : maps out-of-range start indices to song 0
package playlist_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [1:0] REP_SEQ = 2'b00;
  localparam logic [1:0] REP_ALL = 2'b01;
  localparam logic [1:0] REP_ONE = 2'b10;

  // num is the song count (1..256), carried at 9 bits so 256 is representable.
  function automatic logic [7:0] last_idx(input logic [8:0] num);
    logic [8:0] l;
    l = num - 9'd1;
    return l[7:0];
  endfunction

  function automatic logic [7:0] next_idx(input logic [7:0] idx, input logic [8:0] num);
    logic [7:0] r;
    if (idx >= last_idx(num)) r = '0;
    else                      r = idx + 8'd1;
    return r;
  endfunction

  function automatic logic [7:0] prev_idx(input logic [7:0] idx, input logic [8:0] num);
    logic [7:0] r;
    if (idx == 8'd0) r = last_idx(num);
    else             r = idx - 8'd1;
    return r;
  endfunction

  function automatic logic [7:0] clamp_idx(input logic [7:0] idx, input logic [8:0] num);
    logic [7:0] r;
    if ({1'b0, idx} >= num) r = '0;
    else                    r = idx;
    return r;
  endfunction

endpackage

// File: rtl/playlist_sequencer_gap_timer.sv
// Inter-song gap timer.
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : count while high (controller is in GAP)
//   clr_i      : synchronous clear, takes priority over counting
//   done_o     : high during the last of GAP_CYCLES enabled cycles
module gap_timer #(
  parameter int unsigned GAP_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic done_o
);

  localparam int unsigned CW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(GAP_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign done_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || done_o) cnt_d = '0;
    else if (en_i)       cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/playlist_sequencer.sv
// Playlist sequencer: drives song index, player restart and pause between the
// auto-play mode FSM and the song player; handles repeat modes, skip
// next/prev and a fixed silent gap between songs.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start/stop          : begin at start_index / abort to IDLE (pulses)
//   pause_req/resume    : pause / continue current song (pulses)
//   next_req/prev_req   : skip forward / back with wrap (pulses)
//   repeat_mode[1:0]    : 00 sequential, 01 loop-all, 10 repeat-one, 11 = 00
//   start_index[7:0]    : first song, out-of-range treated as 0
//   song_over           : end-of-song pulse from the player
//   index[7:0]          : song index to the player
//   player_rst_n        : low only in LOAD (player restart)
//   player_pause        : low only in PLAY
//   busy                : high in LOAD/PLAY/PAUSE/GAP
//   all_done            : one-cycle pulse on entry to DONE
//   state_o[2:0]        : current state code
module playlist_sequencer
  import playlist_sequencer_pkg::*;
#(
  parameter int unsigned NUM_SONGS  = 4,
  parameter int unsigned GAP_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       pause_req,
  input  logic       resume,
  input  logic       next_req,
  input  logic       prev_req,
  input  logic [1:0] repeat_mode,
  input  logic [7:0] start_index,
  input  logic       song_over,
  output logic [7:0] index,
  output logic       player_rst_n,
  output logic       player_pause,
  output logic       busy,
  output logic       all_done,
  output logic [2:0] state_o
);

  localparam logic [8:0] NUM = 9'(NUM_SONGS);

  state_e     state_q, state_d;
  logic [7:0] index_q, index_d;
  logic       all_done_q, all_done_d;
  logic       gap_en, gap_clr, gap_done;

  // Counter runs only in GAP and is zeroed whenever GAP is not the next state,
  // so it starts from 0 on every entry and is clear after any exit.
  assign gap_en  = (state_q == ST_GAP);
  assign gap_clr = (state_d != ST_GAP);

  gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (gap_en),
    .clr_i (gap_clr),
    .done_o(gap_done)
  );

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    all_done_d = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            index_d = clamp_idx(start_index, NUM);
            state_d = ST_LOAD;
          end
        end

        ST_LOAD: state_d = ST_PLAY;

        ST_PLAY, ST_PAUSE, ST_GAP: begin
          if (next_req) begin
            index_d = next_idx(index_q, NUM);
            state_d = ST_LOAD;
          end else if (prev_req) begin
            index_d = prev_idx(index_q, NUM);
            state_d = ST_LOAD;
          end else if (state_q == ST_PLAY) begin
            if (pause_req) begin
              state_d = ST_PAUSE;
            end else if (song_over) begin
              unique case (repeat_mode)
                REP_ONE: state_d = ST_GAP;
                REP_ALL: begin
                  index_d = next_idx(index_q, NUM);
                  state_d = ST_GAP;
                end
                default: begin
                  if (index_q == last_idx(NUM)) begin
                    state_d    = ST_DONE;
                    all_done_d = 1'b1;
                  end else begin
                    index_d = next_idx(index_q, NUM);
                    state_d = ST_GAP;
                  end
                end
              endcase
            end
          end else if (state_q == ST_PAUSE) begin
            if (resume) state_d = ST_PLAY;
          end else begin
            if (gap_done) state_d = ST_LOAD;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      all_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      all_done_q <= all_done_d;
    end
  end

  assign index        = index_q;
  assign state_o      = state_q;
  assign player_rst_n = (state_q != ST_LOAD);
  assign player_pause = (state_q != ST_PLAY);
  assign busy         = (state_q == ST_LOAD) || (state_q == ST_PLAY) ||
                        (state_q == ST_PAUSE) || (state_q == ST_GAP);
  assign all_done     = all_done_q;

endmodule

// File: tb/tb_playlist_sequencer.sv
module tb_playlist_sequencer;

  localparam int N = 4;
  localparam int G = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, pause_req, resume, next_req, prev_req, song_over;
  logic [1:0] repeat_mode;
  logic [7:0] start_index;
  logic [7:0] index;
  logic       player_rst_n, player_pause, busy, all_done;
  logic [2:0] state_o;

  int tests = 0;
  int failed = 0;

  // Reference model: spec-level state code, song number, cycles spent in gap.
  int m_st, m_idx, m_gap;
  bit m_done;

  playlist_sequencer #(.NUM_SONGS(N), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .pause_req(pause_req), .resume(resume), .next_req(next_req),
    .prev_req(prev_req), .repeat_mode(repeat_mode),
    .start_index(start_index), .song_over(song_over), .index(index),
    .player_rst_n(player_rst_n), .player_pause(player_pause), .busy(busy),
    .all_done(all_done), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_idx = 0; m_gap = 0; m_done = 0;
  endtask

  // One clock of the playlist rules, evaluated on the inputs present now.
  task automatic model_step();
    bit active;
    active = (m_st == 2 || m_st == 3 || m_st == 4);
    m_done = 0;
    if (stop) m_st = 0;
    else if (active && next_req) begin m_idx = (m_idx + 1) % N; m_st = 1; end
    else if (active && prev_req) begin m_idx = (m_idx + N - 1) % N; m_st = 1; end
    else if ((m_st == 0 || m_st == 5) && start) begin
      m_idx = (start_index < N) ? int'(start_index) : 0;
      m_st = 1;
    end
    else if (m_st == 1) m_st = 2;
    else if (m_st == 2 && pause_req) m_st = 3;
    else if (m_st == 3 && resume) m_st = 2;
    else if (m_st == 2 && song_over) begin
      if (repeat_mode == 2'b10) begin m_st = 4; m_gap = 0; end
      else if (repeat_mode == 2'b01) begin m_idx = (m_idx + 1) % N; m_st = 4; m_gap = 0; end
      else if (m_idx == N - 1) begin m_st = 5; m_done = 1; end
      else begin m_idx = m_idx + 1; m_st = 4; m_gap = 0; end
    end
    else if (m_st == 4) begin
      m_gap++;
      if (m_gap == G) m_st = 1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, 32'(state_o), 32'(m_st));
    check({tag, ".index"}, 32'(index), 32'(m_idx));
    check({tag, ".prst"}, 32'(player_rst_n), 32'(m_st != 1));
    check({tag, ".pause"}, 32'(player_pause), 32'(m_st != 2));
    check({tag, ".busy"}, 32'(busy), 32'(m_st >= 1 && m_st <= 4));
    check({tag, ".done"}, 32'(all_done), 32'(m_done));
  endtask

  task automatic clear_pulses();
    start = 0; stop = 0; pause_req = 0; resume = 0;
    next_req = 0; prev_req = 0; song_over = 0;
  endtask

  // Apply current inputs across one rising edge, check, then drop pulses.
  task automatic cyc(input string tag);
    model_step();
    @(posedge clk); #1;
    check_all(tag);
    clear_pulses();
  endtask

  initial begin
    clear_pulses();
    repeat_mode = 2'b00; start_index = 8'd0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("por");
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (3) cyc("idle");

    // start latency
    start = 1; start_index = 8'd1;
    cyc("start1");
    check("lat.prst_low", 32'(player_rst_n), 32'd0);
    cyc("start2");
    check("lat.state_play", 32'(state_o), 32'd2);
    check("lat.index", 32'(index), 32'd1);
    check("lat.pause_low", 32'(player_pause), 32'd0);
    check("lat.prst_high", 32'(player_rst_n), 32'd1);

    // reach index 2 then reset mid-PLAY
    next_req = 1; cyc("nx"); cyc("nx.play");
    check("pre_rst.index", 32'(index), 32'd2);
    rst_n = 1'b0; model_reset(); #1;
    check("midrst.state", 32'(state_o), 32'd0);
    check("midrst.index", 32'(index), 32'd0);
    check("midrst.pause", 32'(player_pause), 32'd1);
    check("midrst.prst", 32'(player_rst_n), 32'd1);
    @(posedge clk); #1; rst_n = 1'b1;

    // sequential: index 2 -> gap -> 3 -> done
    start = 1; start_index = 8'd2; repeat_mode = 2'b00;
    cyc("s2"); cyc("s2p");
    song_over = 1; cyc("so2");
    check("seq.gap", 32'(state_o), 32'd4);
    cyc("gap1"); cyc("gap2");
    check("seq.gap_last", 32'(state_o), 32'd4);
    cyc("gap_end");
    check("seq.load", 32'(state_o), 32'd1);
    cyc("play3");
    check("seq.index3", 32'(index), 32'd3);
    song_over = 1; cyc("so3");
    check("seq.done", 32'(state_o), 32'd5);
    check("seq.all_done", 32'(all_done), 32'd1);
    check("seq.busy", 32'(busy), 32'd0);
    cyc("done2");
    check("seq.all_done_pulse", 32'(all_done), 32'd0);

    // loop-all wrap 3 -> 0
    start = 1; start_index = 8'd3; repeat_mode = 2'b01;
    cyc("la"); cyc("lap");
    song_over = 1; cyc("la.so");
    repeat (3) cyc("la.gap");
    cyc("la.play");
    check("loopall.index0", 32'(index), 32'd0);

    // repeat-one at index 2
    next_req = 1; cyc("r1a"); cyc("r1b");
    next_req = 1; cyc("r1c"); cyc("r1d");
    repeat_mode = 2'b10; song_over = 1; cyc("r1.so");
    repeat (3) cyc("r1.gap");
    check("rep1.load", 32'(state_o), 32'd1);
    check("rep1.index", 32'(index), 32'd2);
    cyc("r1.play");

    // prev wrap from PAUSE at index 0
    prev_req = 1; cyc("pv1"); cyc("pv1p");
    prev_req = 1; cyc("pv0"); cyc("pv0p");
    pause_req = 1; cyc("pz");
    prev_req = 1; cyc("pv.wrap");
    check("prevwrap.index", 32'(index), 32'd3);
    check("prevwrap.load", 32'(state_o), 32'd1);
    cyc("pv.play");

    // song_over + next at index 1
    next_req = 1; cyc("n0"); cyc("n0p");
    next_req = 1; cyc("n1"); cyc("n1p");
    repeat_mode = 2'b00; song_over = 1; next_req = 1; cyc("son");
    check("so_next.index", 32'(index), 32'd2);
    check("so_next.state", 32'(state_o), 32'd1);
    cyc("son.play");

    // pause / resume without restart
    pause_req = 1; cyc("pause");
    check("pr.pause1", 32'(player_pause), 32'd1);
    resume = 1; cyc("resume");
    check("pr.pause0", 32'(player_pause), 32'd0);
    check("pr.prst", 32'(player_rst_n), 32'd1);

    // stop during GAP
    repeat_mode = 2'b01; song_over = 1; cyc("stg.so");
    cyc("stg.gap");
    stop = 1; cyc("stop");
    check("stop.idle", 32'(state_o), 32'd0);
    check("stop.index", 32'(index), 32'd3);

    // out-of-range start index clamps to 0
    start = 1; start_index = 8'd200; cyc("clamp");
    check("clamp.index", 32'(index), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      stop        = ($urandom_range(63) == 0);
      next_req    = ($urandom_range(19) == 0);
      prev_req    = ($urandom_range(19) == 0);
      start       = ($urandom_range(7) == 0);
      pause_req   = ($urandom_range(9) == 0);
      resume      = ($urandom_range(5) == 0);
      song_over   = ($urandom_range(4) == 0);
      repeat_mode = 2'($urandom_range(3));
      start_index = 8'($urandom_range(7));
      cyc("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
